// File: rtl/demux_1to2_32bit_buf_if.sv
// rtl/demux_1to2_32bit_buf_if.sv - source and sink bundle of the buffered 1-to-2 word demux
// The slave side is the demux; the master side is whatever drives the source and consumes both sinks.
interface demux_1to2_32bit_buf_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;

  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;

  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
  );

  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
  );
endinterface

// File: rtl/demux_1to2_32bit_buf.sv
// rtl/demux_1to2_32bit_buf.sv - buffered 1-to-2 word demux with a FIFO and delivery counter per sink
// Each queue tracks occupancy with a count plus an EMPTY/PARTIAL/FULL state decoded from the next count.
module demux_1to2_32bit_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input logic                    clock,
  input logic                    reset,
  demux_1to2_32bit_buf_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CQ_W  = PTR_W + 1;
  localparam logic [CQ_W-1:0] FULL_CNT = CQ_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } q_state_e;

  logic [WIDTH-1:0] mem_q    [2][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [2];
  logic [PTR_W-1:0] wr_ptr_d [2];
  logic [PTR_W-1:0] rd_ptr_q [2];
  logic [PTR_W-1:0] rd_ptr_d [2];
  logic [CQ_W-1:0]  count_q  [2];
  logic [CQ_W-1:0]  count_d  [2];
  q_state_e         state_q  [2];
  q_state_e         state_d  [2];
  logic [CNT_W-1:0] cnt_q    [2];
  logic [CNT_W-1:0] cnt_d    [2];

  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_valid;
  logic [1:0] out_ready;
  logic       in_ready;

  assign out_ready = {bus.out1_ready, bus.out0_ready};

  // A full queue refuses a push even if it pops this cycle: no push-through.
  always_comb begin
    in_ready = 1'b1;
    if (bus.in_sel) begin
      in_ready = (state_q[1] != ST_FULL);
    end else begin
      in_ready = (state_q[0] != ST_FULL);
    end
  end

  always_comb begin
    push = 2'b00;
    out_valid = 2'b00;
    for (int q = 0; q < 2; q++) begin
      out_valid[q] = (state_q[q] != ST_EMPTY);
      push[q]      = bus.in_valid & in_ready & (bus.in_sel == 1'(q));
    end
    pop = out_valid & out_ready;
  end

  always_comb begin
    for (int q = 0; q < 2; q++) begin
      wr_ptr_d[q] = wr_ptr_q[q];
      rd_ptr_d[q] = rd_ptr_q[q];
      count_d[q]  = count_q[q];
      cnt_d[q]    = cnt_q[q];
      state_d[q]  = state_q[q];

      if (push[q]) begin
        wr_ptr_d[q] = wr_ptr_q[q] + PTR_W'(1);
      end
      if (pop[q]) begin
        rd_ptr_d[q] = rd_ptr_q[q] + PTR_W'(1);
        cnt_d[q]    = cnt_q[q] + CNT_W'(1);
      end

      case ({push[q], pop[q]})
        2'b10:   count_d[q] = count_q[q] + CQ_W'(1);
        2'b01:   count_d[q] = count_q[q] - CQ_W'(1);
        default: count_d[q] = count_q[q];
      endcase

      if (count_d[q] == '0) begin
        state_d[q] = ST_EMPTY;
      end else if (count_d[q] == FULL_CNT) begin
        state_d[q] = ST_FULL;
      end else begin
        state_d[q] = ST_PARTIAL;
      end
    end
  end

  // Storage is cleared on reset so both heads read zero afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int q = 0; q < 2; q++) begin
        for (int e = 0; e < DEPTH; e++) begin
          mem_q[q][e] <= '0;
        end
        wr_ptr_q[q] <= '0;
        rd_ptr_q[q] <= '0;
        count_q[q]  <= '0;
        cnt_q[q]    <= '0;
        state_q[q]  <= ST_EMPTY;
      end
    end else begin
      for (int q = 0; q < 2; q++) begin
        if (push[q]) begin
          mem_q[q][wr_ptr_q[q]] <= bus.in_data;
        end
        wr_ptr_q[q] <= wr_ptr_d[q];
        rd_ptr_q[q] <= rd_ptr_d[q];
        count_q[q]  <= count_d[q];
        cnt_q[q]    <= cnt_d[q];
        state_q[q]  <= state_d[q];
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out0_valid = out_valid[0];
  assign bus.out1_valid = out_valid[1];
  assign bus.out0_data  = mem_q[0][rd_ptr_q[0]];
  assign bus.out1_data  = mem_q[1][rd_ptr_q[1]];
  assign bus.cnt0       = cnt_q[0];
  assign bus.cnt1       = cnt_q[1];

endmodule

// File: tb/tb_demux_1to2_32bit_buf.sv
// tb/tb_demux_1to2_32bit_buf.sv - directed bench with a per-sink scoreboard for demux_1to2_32bit_buf
`timescale 1ns/1ps
module tb_demux_1to2_32bit_buf;

  logic clock = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp0 [$];
  logic [31:0] exp1 [$];
  logic [3:0]  mcnt0 = 4'd0;
  logic [3:0]  mcnt1 = 4'd0;

  demux_1to2_32bit_buf_if #(.WIDTH(32), .CNT_W(4)) bus ();

  demux_1to2_32bit_buf #(.WIDTH(32), .DEPTH(2), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: words enter at accepted pushes, leave at pops; counters follow pops.
  always @(negedge clock) begin : monitor
    logic [31:0] w;
    check("cnt0_model", 32'(bus.cnt0), 32'(mcnt0));
    check("cnt1_model", 32'(bus.cnt1), 32'(mcnt1));
    if (reset) begin
      exp0.delete();
      exp1.delete();
      mcnt0 = 4'd0;
      mcnt1 = 4'd0;
    end else begin
      if (bus.out0_valid && bus.out0_ready) begin
        if (exp0.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL out0_unexpected: observed word %0h expected no word", bus.out0_data);
        end else begin
          w = exp0.pop_front();
          check("out0_order", bus.out0_data, w);
        end
        mcnt0 = mcnt0 + 4'd1;
      end
      if (bus.out1_valid && bus.out1_ready) begin
        if (exp1.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL out1_unexpected: observed word %0h expected no word", bus.out1_data);
        end else begin
          w = exp1.pop_front();
          check("out1_order", bus.out1_data, w);
        end
        mcnt1 = mcnt1 + 4'd1;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (bus.in_sel) exp1.push_back(bus.in_data);
        else            exp0.push_back(bus.in_data);
      end
    end
  end

  initial begin
    reset          = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_data    = 32'hDEAD_BEEF;
    bus.in_sel     = 1'b0;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;

    // reset with a word on offer
    repeat (2) @(posedge clock);
    #1 reset = 1'b0; bus.in_valid = 1'b0;
    @(negedge clock);
    check("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
    check("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
    check("rst_out0_data", bus.out0_data, 32'd0);
    check("rst_out1_data", bus.out1_data, 32'd0);
    check("rst_cnt0", 32'(bus.cnt0), 32'd0);
    check("rst_cnt1", 32'(bus.cnt1), 32'd0);
    check("rst_in_ready_sel0", 32'(bus.in_ready), 32'd1);
    #1 bus.in_sel = 1'b1;
    #1 check("rst_in_ready_sel1", 32'(bus.in_ready), 32'd1);

    // routing
    @(posedge clock); #1 bus.in_valid = 1'b1; bus.in_data = 32'd0; bus.in_sel = 1'b0;
    @(posedge clock); #1 bus.in_data = 32'd123; bus.in_sel = 1'b1;
    @(negedge clock);
    check("route_out0_valid_a", 32'(bus.out0_valid), 32'd1);
    check("route_out0_data_a", bus.out0_data, 32'd0);
    @(posedge clock); #1 bus.in_data = 32'hFFFF_FFFF; bus.in_sel = 1'b0;
    @(negedge clock);
    check("route_out1_valid", 32'(bus.out1_valid), 32'd1);
    check("route_out1_data", bus.out1_data, 32'd123);
    check("route_out0_idle", 32'(bus.out0_valid), 32'd0);
    @(posedge clock); #1 bus.in_valid = 1'b0;
    @(negedge clock);
    check("route_out0_valid_b", 32'(bus.out0_valid), 32'd1);
    check("route_out0_data_b", bus.out0_data, 32'hFFFF_FFFF);
    @(posedge clock); #1;
    @(negedge clock);
    check("route_cnt0", 32'(bus.cnt0), 32'd2);
    check("route_cnt1", 32'(bus.cnt1), 32'd1);

    // backpressure isolation
    @(posedge clock); #1 bus.out0_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 32'hA; bus.in_sel = 1'b0;
    @(posedge clock); #1 bus.in_data = 32'hB;
    @(posedge clock); #1 bus.in_valid = 1'b0; bus.in_sel = 1'b0;
    @(negedge clock);
    check("bp_in_ready_sel0", 32'(bus.in_ready), 32'd0);
    check("bp_out0_head", bus.out0_data, 32'hA);
    #1 bus.in_sel = 1'b1;
    #1 check("bp_in_ready_sel1", 32'(bus.in_ready), 32'd1);
    @(posedge clock); #1 bus.in_valid = 1'b1; bus.in_data = 32'h5; bus.in_sel = 1'b1;
    @(posedge clock); #1 bus.in_valid = 1'b0;
    @(negedge clock);
    check("bp_out1_valid", 32'(bus.out1_valid), 32'd1);
    check("bp_out1_data", bus.out1_data, 32'h5);
    check("bp_out0_held", bus.out0_data, 32'hA);

    // full queue with same-cycle pop
    @(posedge clock); #1 bus.out0_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'hC; bus.in_sel = 1'b0;
    @(negedge clock);
    check("full_in_ready_blocked", 32'(bus.in_ready), 32'd0);
    check("full_head_a", bus.out0_data, 32'hA);
    @(posedge clock); #1;
    @(negedge clock);
    check("full_in_ready_free", 32'(bus.in_ready), 32'd1);
    check("full_head_b", bus.out0_data, 32'hB);
    @(posedge clock); #1 bus.in_valid = 1'b0;
    @(negedge clock);
    check("full_head_c", bus.out0_data, 32'hC);
    @(posedge clock); #1;
    @(negedge clock);
    check("full_drained", 32'(bus.out0_valid), 32'd0);
    check("full_cnt0", 32'(bus.cnt0), 32'd5);
    check("full_cnt1", 32'(bus.cnt1), 32'd2);

    // counter wrap on out1
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0; bus.in_valid = 1'b1; bus.in_sel = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.in_data = 32'h100 + 32'(i);
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    check("wrap_cnt1", 32'(bus.cnt1), 32'd1);
    check("wrap_cnt0", 32'(bus.cnt0), 32'd0);

    // reset mid-operation
    @(posedge clock); #1 bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 32'h11;
    @(posedge clock); #1 bus.in_data = 32'h22;
    @(posedge clock); #1 bus.in_sel = 1'b1; bus.in_data = 32'h33;
    @(posedge clock); #1 bus.in_valid = 1'b0;
    @(negedge clock);
    check("mid_out0_loaded", 32'(bus.out0_valid), 32'd1);
    check("mid_out1_loaded", 32'(bus.out1_valid), 32'd1);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("mid_out0_valid", 32'(bus.out0_valid), 32'd0);
    check("mid_out1_valid", 32'(bus.out1_valid), 32'd0);
    check("mid_out0_data", bus.out0_data, 32'd0);
    check("mid_cnt0", 32'(bus.cnt0), 32'd0);
    check("mid_cnt1", 32'(bus.cnt1), 32'd0);
    @(posedge clock); #1 bus.out1_ready = 1'b1; bus.in_valid = 1'b1; bus.in_sel = 1'b1; bus.in_data = 32'h77;
    @(posedge clock); #1 bus.in_valid = 1'b0;
    @(negedge clock);
    check("mid_out1_new_valid", 32'(bus.out1_valid), 32'd1);
    check("mid_out1_new_data", bus.out1_data, 32'h77);
    check("mid_out0_stays_empty", 32'(bus.out0_valid), 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check("mid_out1_alone", 32'(bus.out1_valid), 32'd0);
    check("mid_cnt1_after", 32'(bus.cnt1), 32'd1);

    check("sb_exp0_drained", 32'(exp0.size()), 32'd0);
    check("sb_exp1_drained", 32'(exp1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1to2_32bit_buf.md
# demux_1to2_32bit_buf

Buffered 1-to-2 demultiplexer: routes each accepted 32-bit word from a single valid/ready source to one of two destinations chosen by a per-word select bit. It is the steering counterpart of the 2-to-1 word mux and is used in the MIPS datapath to split one result stream into two consumers, for example the write-back path and a forwarding/debug sink. Each destination has its own small FIFO, so a stalled consumer does not block traffic to the other. Per-destination delivery counters support bring-up and verification.

## Interface
- WIDTH, 32, data word width.
- DEPTH, 2, entries per destination queue; power of two, ≥2.
- CNT_W, 16, width of each delivery counter.

- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  word offered by the source.
- in_sel  in  1  destination of in_data: 0 → out0, 1 → out1.
- in_valid  in  1  source offers in_data/in_sel.
- in_ready  out  1  block accepts the word this cycle.
- out0_data  out  WIDTH  head word of queue 0.
- out0_valid  out  1  queue 0 non-empty.
- out0_ready  in  1  consumer 0 takes the head word.
- out1_data, out1_valid, out1_ready: same as the out0 signals, for queue 1.
- cnt0, cnt1  out  CNT_W  number of words delivered on out0/out1, modulo 2^CNT_W.

## Operation
- Push: a word is accepted when in_valid & in_ready. It is written to queue[in_sel] at the rising edge.
- in_ready = ~full[in_sel]. This is a combinational path from in_sel to in_ready; it has no dependence on in_valid or outN_ready.
- Full means count == DEPTH. A pop in the same cycle does not free a slot for a push into a full queue: no push-through-when-full.
- Pop: queue N pops at the edge when outN_valid & outN_ready. outN_valid = (countN != 0).
- outN_data is the head entry of queue N and is held stable while outN_valid is high and outN_ready is low.
- Each queue has its own states, derived from its count:
  - EMPTY (0): push → PARTIAL, or FULL if DEPTH were 1 (not allowed).
  - PARTIAL: push-only → count+1; pop-only → count−1; push+pop → count unchanged.
  - FULL (DEPTH): pop → PARTIAL; push is blocked.
- Pointers wrap modulo DEPTH.
- Ordering: FIFO order is preserved within each destination. There is no ordering guarantee between out0 and out1.
- Counters: cntN increments by 1 on each pop of queue N and wraps from 2^CNT_W−1 to 0. A push does not affect the counter.
- Simultaneous events:
  - A push to one queue and a pop from the other are independent.
  - Both queues may pop in the same cycle.
  - A word is never duplicated or dropped.
- Reset, including mid-operation:
  - All queue contents, pointers, counts and counters are cleared in the cycle reset is high.
  - Words in flight are discarded.
  - A handshake that coincides with reset is ignored.

## Timing
- Reset values: out0_valid = out1_valid = 0; out0_data = out1_data = 0 (storage cleared); cnt0 = cnt1 = 0; in_ready = 1 for either in_sel.
- Latency: a word accepted at edge k appears on outN_valid/outN_data after edge k, i.e. in cycle k+1. There is no combinational bypass from in_data to outN_data.
- Throughput: one word per cycle per destination when the consumer holds outN_ready high. One input word per cycle overall.
- cntN updates at the same edge as the pop, so it is visible the following cycle.
- All outputs except in_ready are registered or are decoded from registered state.

## Test plan
- Reset: assert reset for 2 cycles with in_valid = 1 → out0_valid = out1_valid = 0, out0_data = out1_data = 0, cnt0 = cnt1 = 0, in_ready = 1; no word is captured.
- Routing:
  - Setup: out0_ready = out1_ready = 1.
  - Stimulus: push 32'd0 with sel = 0, then 32'd123 with sel = 1, then 32'hFFFF_FFFF with sel = 0, on consecutive cycles.
  - Required response: out0 delivers 0 then FFFFFFFF, each one cycle after its push; out1 delivers 123; cnt0 = 2, cnt1 = 1.
- Backpressure isolation:
  - Setup: out0_ready = 0.
  - Stimulus: push 0xA and then 0xB to sel 0.
  - Required response: in_ready = 0 while in_sel = 0 and in_ready = 1 while in_sel = 1; pushing 0x5 to sel 1 is accepted and delivered. Raising out0_ready then delivers 0xA and then 0xB, in order.
- Full with same-cycle pop: with queue 0 full and out0_ready = 1, offer 0xC on sel 0 → not accepted that cycle (in_ready = 0), accepted next cycle; delivery order is 0xA, 0xB, 0xC.
- Counter wrap: with CNT_W = 4, deliver 17 words on out1 → cnt1 = 1 and cnt0 = 0.
- Reset mid-operation: with queue 0 holding 2 words and queue 1 holding 1 word, pulse reset for 1 cycle → both valids drop to 0 the next cycle, counters read 0, and a subsequent push of 0x77 to sel 1 is delivered alone.
